regfile_mp: RTL and testbench

- Parametrised multi-port register file; next generation of the pipeline's 32x32 register file.
- Generalised in data width, depth, number of read ports and number of write ports.
- Two write ports let ALU write-back and load write-back retire in the same cycle.
- Adds a sequential sweep-clear engine, a ready flag and optional same-cycle write-to-read bypass.
- Sits between the decode stage (reads) and the write-back stage (writes).

---
 rtl/regfile_mp_if.sv | 30 +++
 rtl/regfile_mp.sv | 132 +++++++++++++
 tb/tb_regfile_mp.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_mp_if.sv
// Bus bundle between the pipeline (decode reads, write-back writes) and regfile_mp.
// Packed per-port fields: port k occupies [k*W +: W] of each vector.
interface regfile_mp_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NUM_RD = 2,
  parameter int unsigned NUM_WR = 2
);

  logic                     clr_req;
  logic                     ready;
  logic [NUM_WR-1:0]        we;
  logic [NUM_WR*ADDR_W-1:0] wa;
  logic [NUM_WR*DATA_W-1:0] wd;
  logic [NUM_RD*ADDR_W-1:0] ra;
  logic [NUM_RD*DATA_W-1:0] rd;

  // Pipeline side: issues writes, read addresses and clear requests.
  modport master (
    output clr_req, we, wa, wd, ra,
    input  ready, rd
  );

  // Register-file side.
  modport slave (
    input  clr_req, we, wa, wd, ra,
    output ready, rd
  );

endinterface

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with sweep-clear engine and ready flag.
// Register 0 reads as zero; writes to it are dropped. Higher-index write port wins.
// Optional macro REGFILE_BYPASS_EN: same-cycle write-to-read bypass when ready.
module regfile_mp #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NUM_RD = 2,
  parameter int unsigned NUM_WR = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  regfile_mp_if.slave  rf_io
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LastPtr = ADDR_W'(DEPTH - 1);

  typedef enum logic [0:0] {
    StClear,
    StReady
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              ready_q, ready_d;
  logic              clr_en;
  logic              wr_allow;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  logic [ADDR_W-1:0] wa_u [NUM_WR];
  logic [DATA_W-1:0] wd_u [NUM_WR];
  logic [ADDR_W-1:0] ra_u [NUM_RD];
  logic [NUM_RD*DATA_W-1:0] rd_flat;

  // Unpack the per-port fields of the bus.
  for (genvar k = 0; k < NUM_WR; k++) begin : g_wr_unpack
    assign wa_u[k] = rf_io.wa[k*ADDR_W +: ADDR_W];
    assign wd_u[k] = rf_io.wd[k*DATA_W +: DATA_W];
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd_unpack
    assign ra_u[i] = rf_io.ra[i*ADDR_W +: ADDR_W];
  end

  // FSM state, sweep pointer and registered ready flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StClear;
      ptr_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ready_q <= ready_d;
    end
  end

  // Next state: sweep DEPTH entries, then serve until a clear request arrives.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      StClear: begin
        if (ptr_q == LastPtr) begin
          ptr_d   = '0;
          state_d = StReady;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      StReady: begin
        if (rf_io.clr_req) begin
          ptr_d   = '0;
          state_d = StClear;
        end
      end
      default: begin
        ptr_d   = '0;
        state_d = StClear;
      end
    endcase
    ready_d = (state_d == StReady);
  end

  // FSM outputs: clear strobe during the sweep, write permission when ready.
  always_comb begin
    clr_en   = (state_q == StClear);
    wr_allow = ready_q;
  end

  // Array next state: sweep zeroing, else prioritised port writes (last port wins).
  always_comb begin
    mem_d = mem_q;
    if (clr_en) begin
      mem_d[ptr_q] = '0;
    end else if (wr_allow) begin
      for (int unsigned k = 0; k < NUM_WR; k++) begin
        if (rf_io.we[k] && (wa_u[k] != '0)) begin
          mem_d[wa_u[k]] = wd_u[k];
        end
      end
    end
  end

  // Storage array; contents are initialised by the sweep, not by reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Combinational reads; zero while not ready and for register 0.
  always_comb begin
    rd_flat = '0;
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      if (ready_q && (ra_u[i] != '0)) begin
        rd_flat[i*DATA_W +: DATA_W] = mem_q[ra_u[i]];
`ifdef REGFILE_BYPASS_EN
        for (int unsigned k = 0; k < NUM_WR; k++) begin
          if (rf_io.we[k] && (wa_u[k] == ra_u[i])) begin
            rd_flat[i*DATA_W +: DATA_W] = wd_u[k];
          end
        end
`endif
      end
    end
  end

  assign rf_io.rd    = rd_flat;
  assign rf_io.ready = ready_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp against a behavioural register-file model.
module tb_regfile_mp;

  logic clk;
  logic rst_n;

  regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2)) rf_if ();

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rf_io (rf_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: 32 architectural registers plus remaining sweep cycles.
  logic [31:0] model [32];
  int          sweep_left;
  int          n_tests;
  int          n_fail;

  task automatic model_reset();
    sweep_left = 32;
    for (int a = 0; a < 32; a++) model[a] = '0;
  endtask

  // Applies the effect of the coming posedge to the model.
  task automatic model_commit();
    if (!rst_n) begin
      model_reset();
    end else if (sweep_left > 0) begin
      sweep_left--;
    end else if (rf_if.clr_req) begin
      model_reset();
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (rf_if.we[k] && rf_if.wa[k*5 +: 5] != 5'd0) model[rf_if.wa[k*5 +: 5]] = rf_if.wd[k*32 +: 32];
      end
    end
  endtask

  function automatic logic [31:0] exp_rd(input int p);
    logic [4:0]  a;
    logic [31:0] v;
    a = rf_if.ra[p*5 +: 5];
    if (!rst_n || sweep_left > 0 || a == 5'd0) return 32'd0;
    v = model[a];
`ifdef REGFILE_BYPASS_EN
    for (int k = 0; k < 2; k++) begin
      if (rf_if.we[k] && rf_if.wa[k*5 +: 5] == a) v = rf_if.wd[k*32 +: 32];
    end
`endif
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_wr(input logic [1:0] we, input logic [4:0] a0, input logic [31:0] d0,
                        input logic [4:0] a1, input logic [31:0] d1);
    rf_if.we = we;
    rf_if.wa = {a1, a0};
    rf_if.wd = {d1, d0};
  endtask

  task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
    rf_if.ra = {a1, a0};
  endtask

  // Settle to the negedge and compare every output with the model.
  task automatic half();
    @(negedge clk);
    chk("ready", {31'd0, rf_if.ready}, {31'd0, (rst_n && sweep_left == 0)});
    chk("rd0", rf_if.rd[31:0], exp_rd(0));
    chk("rd1", rf_if.rd[63:32], exp_rd(1));
  endtask

  task automatic adv();
    model_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle();
    half();
    adv();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    rf_if.clr_req = 1'b0;
    set_wr(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    set_rd(5'd3, 5'd4);
    model_reset();

    // Reset then idle: ready low for exactly 32 cycles.
    @(posedge clk);
    #1;
    cycle();
    rst_n = 1'b1;
    for (int c = 0; c < 32; c++) begin
      set_rd(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      half();
      chk("sweep_ready_low", {31'd0, rf_if.ready}, 32'd0);
      adv();
    end
    half();
    chk("ready_after_reset", {31'd0, rf_if.ready}, 32'd1);
    chk("rd0_after_reset", rf_if.rd[31:0], 32'd0);
    adv();

    // Dual write.
    set_wr(2'b11, 5'd3, 32'h1111_1111, 5'd4, 32'h2222_2222);
    cycle();
    set_wr(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    set_rd(5'd3, 5'd4);
    half();
    chk("dual_r3", rf_if.rd[31:0], 32'h1111_1111);
    chk("dual_r4", rf_if.rd[63:32], 32'h2222_2222);
    adv();

    // Write conflict and write to r0.
    set_wr(2'b11, 5'd7, 32'hAAAA_0000, 5'd7, 32'h0000_BBBB);
    cycle();
    set_wr(2'b01, 5'd0, 32'hFFFF_FFFF, 5'd0, 32'd0);
    cycle();
    set_wr(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    set_rd(5'd7, 5'd0);
    half();
    chk("conflict_r7", rf_if.rd[31:0], 32'h0000_BBBB);
    chk("r0_zero", rf_if.rd[63:32], 32'd0);
    adv();

    // Bypass / write-visibility timing.
    set_wr(2'b01, 5'd5, 32'h1234_5678, 5'd0, 32'd0);
    cycle();
    set_wr(2'b01, 5'd5, 32'hDEAD_BEEF, 5'd0, 32'd0);
    set_rd(5'd5, 5'd5);
    half();
`ifdef REGFILE_BYPASS_EN
    chk("bypass_same_cycle", rf_if.rd[31:0], 32'hDEAD_BEEF);
`else
    chk("no_bypass_old", rf_if.rd[31:0], 32'h1234_5678);
`endif
    adv();
    set_wr(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    half();
    chk("after_commit", rf_if.rd[31:0], 32'hDEAD_BEEF);
    adv();

    // Fill r1..r31, then clear request.
    for (int a = 1; a < 32; a += 2) begin
      set_wr(2'b11, 5'(a), 32'hA500_0000 | 32'(a), 5'((a + 1) % 32), 32'h5A00_0000 | 32'(a + 1));
      set_rd(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      cycle();
    end
    set_wr(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    set_rd(5'd31, 5'd1);
    half();
    chk("fill_r31", rf_if.rd[31:0], 32'hA500_001F);
    adv();
    rf_if.clr_req = 1'b1;
    cycle();
    rf_if.clr_req = 1'b0;
    for (int c = 0; c < 32; c++) begin
      set_wr(2'b11, 5'd9, 32'hCAFE_0000, 5'd10, 32'hCAFE_0001);
      half();
      chk("clr_ready_low", {31'd0, rf_if.ready}, 32'd0);
      adv();
    end
    set_wr(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    for (int a = 0; a < 32; a += 2) begin
      set_rd(5'(a), 5'(a + 1));
      half();
      chk("post_clr_even", rf_if.rd[31:0], 32'd0);
      chk("post_clr_odd", rf_if.rd[63:32], 32'd0);
      adv();
    end

    // Reset 10 cycles into a sweep.
    rf_if.clr_req = 1'b1;
    cycle();
    rf_if.clr_req = 1'b0;
    for (int c = 0; c < 10; c++) cycle();
    rst_n = 1'b0;
    model_reset();
    half();
    chk("midreset_ready", {31'd0, rf_if.ready}, 32'd0);
    adv();
    rst_n = 1'b1;
    for (int c = 0; c < 32; c++) begin
      half();
      chk("restart_ready_low", {31'd0, rf_if.ready}, 32'd0);
      adv();
    end
    half();
    chk("restart_ready_high", {31'd0, rf_if.ready}, 32'd1);
    adv();

    // Randomised traffic against the model.
    for (int c = 0; c < 400; c++) begin
      set_wr(2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), $urandom(),
             5'($urandom_range(0, 31)), $urandom());
      if ($urandom_range(0, 7) == 0) begin
        // Force an address collision between ports or with a read.
        rf_if.wa[9:5] = rf_if.wa[4:0];
      end
      set_rd(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      if ($urandom_range(0, 3) == 0) rf_if.ra[4:0] = rf_if.wa[4:0];
      rf_if.clr_req = ($urandom_range(0, 99) == 0);
      cycle();
    end
    rf_if.clr_req = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
